jump_scene_renderer: RTL and testbench

- Pixel-colour generator directly upstream of the VGA timing block.
- Consumes the VGA block's current scan coordinate (11-bit x/y) and drives its 4-bit R/G/B colour inputs with the jump-game scene: sky, ground, player, two obstacles.
- Game-state inputs are shadowed once per frame, so a frame never tears.
- Produces a per-frame collision flag and a frame counter for the game logic.

---
 rtl/jump_scene_renderer.sv | 167 ++++++++++++++++
 tb/tb_jump_scene_renderer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jump_scene_renderer.sv
// Jump-game scene pixel generator. Sits upstream of the VGA timing block:
// takes the current scan coordinate and returns its colour one clock later.
// Game state is shadowed at the frame boundary (x==0,y==0) so a frame is
// always drawn from one consistent snapshot. Also produces a frame counter
// and a per-frame player/obstacle collision flag.
//
// Interface timing: there is no valid/ready handshake. Every clock carries
// one coordinate on i_x/i_y, and o_r/o_g/o_b on the following cycle hold the
// colour for that coordinate. There is no backpressure and no bubble.
module jump_scene_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int GROUND_Y  = 400,
  parameter int PLAYER_X  = 80,
  parameter int PLAYER_W  = 32,
  parameter int PLAYER_H  = 32,
  parameter int OBS_W     = 16,
  parameter int OBS_H     = 32,
  parameter int BLINK_BIT = 3
) (
  input  logic        clk_vga,
  input  logic        rst_vga,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic [10:0] i_player_y,
  input  logic [10:0] i_obs0_x,
  input  logic [10:0] i_obs1_x,
  input  logic        i_game_over,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic [7:0]  o_frame_cnt,
  output logic        o_collision
);

  // All geometry is compared in 12 bits so that edge+size never wraps.
  localparam logic [11:0] H_ACT12   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT12   = 12'(V_ACTIVE);
  localparam logic [11:0] GROUND12  = 12'(GROUND_Y);
  localparam logic [11:0] PL_X0     = 12'(PLAYER_X);
  localparam logic [11:0] PL_X1     = 12'(PLAYER_X + PLAYER_W);
  localparam logic [11:0] PL_H12    = 12'(PLAYER_H);
  localparam logic [11:0] OBS_W12   = 12'(OBS_W);
  localparam logic [11:0] OBS_Y0    = 12'(GROUND_Y - OBS_H);

  // Colour constants, packed {r,g,b}.
  localparam logic [11:0] COL_PLAYER = 12'hF00;
  localparam logic [11:0] COL_OBS    = 12'h0F0;
  localparam logic [11:0] COL_GROUND = 12'h630;
  localparam logic [11:0] COL_SKY    = 12'h8CF;
  localparam logic [11:0] COL_BLACK  = 12'h000;

  // Per-frame snapshot of game state.
  logic [10:0] sh_player_y;
  logic [10:0] sh_obs0_x;
  logic [10:0] sh_obs1_x;
  logic        sh_game_over;

  logic        hit_acc;
  logic [11:0] rgb_q;
  logic [11:0] rgb_d;

  // Scan position and derived bounds.
  logic [11:0] x12;
  logic [11:0] y12;
  logic [11:0] py0;
  logic [11:0] py1;
  logic [11:0] ox0_lo;
  logic [11:0] ox0_hi;
  logic [11:0] ox1_lo;
  logic [11:0] ox1_hi;

  logic frame_start;
  logic active;
  logic in_ground;
  logic in_obs_rows;
  logic in_player;
  logic player_vis;
  logic in_obs0;
  logic in_obs1;
  logic in_obs;
  logic pixel_hit;

  assign x12    = {1'b0, i_x};
  assign y12    = {1'b0, i_y};
  assign py0    = {1'b0, sh_player_y};
  assign py1    = py0 + PL_H12;
  assign ox0_lo = {1'b0, sh_obs0_x};
  assign ox0_hi = ox0_lo + OBS_W12;
  assign ox1_lo = {1'b0, sh_obs1_x};
  assign ox1_hi = ox1_lo + OBS_W12;

  assign frame_start = (i_x == 11'd0) && (i_y == 11'd0);

  // Classify the current pixel against the shadowed scene.
  always_comb begin
    active      = (x12 < H_ACT12) && (y12 < V_ACT12);
    in_ground   = (y12 >= GROUND12);
    in_obs_rows = (y12 >= OBS_Y0) && (y12 < GROUND12);
    in_player   = (x12 >= PL_X0) && (x12 < PL_X1) &&
                  (y12 >= py0) && (y12 < py1);
    // Blinking only hides the sprite; collision still uses in_player.
    player_vis  = in_player && !(sh_game_over && o_frame_cnt[BLINK_BIT]);
    // A hidden obstacle is parked at or beyond the right edge. One that
    // straddles the edge is clipped by the active test below.
    in_obs0     = (ox0_lo < H_ACT12) && (x12 >= ox0_lo) && (x12 < ox0_hi) &&
                  in_obs_rows;
    in_obs1     = (ox1_lo < H_ACT12) && (x12 >= ox1_lo) && (x12 < ox1_hi) &&
                  in_obs_rows;
    in_obs      = in_obs0 || in_obs1;
    pixel_hit   = active && in_player && in_obs;
  end

  // Pick the colour by priority: player, obstacle, ground, sky.
  always_comb begin
    rgb_d = COL_BLACK;
    if (active) begin
      if (player_vis) begin
        rgb_d = COL_PLAYER;
      end else if (in_obs) begin
        rgb_d = COL_OBS;
      end else if (in_ground) begin
        rgb_d = COL_GROUND;
      end else begin
        rgb_d = COL_SKY;
      end
    end
  end

  // Register the colour; the VGA block expects exactly one cycle of latency.
  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      rgb_q <= COL_BLACK;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign o_r = rgb_q[11:8];
  assign o_g = rgb_q[7:4];
  assign o_b = rgb_q[3:0];

  // Frame bookkeeping: shadow load, frame count, collision hand-off.
  always_ff @(posedge clk_vga) begin
    if (rst_vga) begin
      sh_player_y  <= '0;
      sh_obs0_x    <= '0;
      sh_obs1_x    <= '0;
      sh_game_over <= 1'b0;
      o_frame_cnt  <= '0;
      o_collision  <= 1'b0;
      hit_acc      <= 1'b0;
    end else if (frame_start) begin
      sh_player_y  <= i_player_y;
      sh_obs0_x    <= i_obs0_x;
      sh_obs1_x    <= i_obs1_x;
      sh_game_over <= i_game_over;
      o_frame_cnt  <= o_frame_cnt + 8'd1;
      o_collision  <= hit_acc;
      // The boundary pixel belongs to the new frame's accumulation.
      hit_acc      <= pixel_hit;
    end else begin
      hit_acc      <= hit_acc | pixel_hit;
    end
  end

endmodule

// File: tb/tb_jump_scene_renderer.sv
// Directed bench for jump_scene_renderer. Coordinates are presented one per
// clock; outputs are sampled 1 time unit after the edge that registered them.
module tb_jump_scene_renderer;

  logic        clk_vga;
  logic        rst_vga;
  logic [10:0] i_x;
  logic [10:0] i_y;
  logic [10:0] i_player_y;
  logic [10:0] i_obs0_x;
  logic [10:0] i_obs1_x;
  logic        i_game_over;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;
  logic [7:0]  o_frame_cnt;
  logic        o_collision;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  exp_cnt;
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  jump_scene_renderer dut (
    .clk_vga     (clk_vga),
    .rst_vga     (rst_vga),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_player_y  (i_player_y),
    .i_obs0_x    (i_obs0_x),
    .i_obs1_x    (i_obs1_x),
    .i_game_over (i_game_over),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b),
    .o_frame_cnt (o_frame_cnt),
    .o_collision (o_collision)
  );

  // Clock
  initial begin
    clk_vga = 1'b0;
    forever #5 clk_vga = ~clk_vga;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one coordinate, then wait until its colour is registered.
  task automatic step(input int x, input int y);
    i_x = 11'(x);
    i_y = 11'(y);
    @(posedge clk_vga);
    #1;
  endtask

  // Present a frame boundary and advance the bench's frame count.
  task automatic boundary();
    step(0, 0);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  function automatic logic [11:0] rgb();
    return {o_r, o_g, o_b};
  endfunction

  initial begin
    exp_cnt     = 8'd0;
    rst_vga     = 1'b1;
    i_x         = 11'd100;
    i_y         = 11'd200;
    i_player_y  = 11'd0;
    i_obs0_x    = 11'd0;
    i_obs1_x    = 11'd0;
    i_game_over = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
    check("reset_rgb", 32'(rgb()), 32'h000);
    check("reset_cnt", 32'(o_frame_cnt), 32'd0);
    check("reset_col", 32'(o_collision), 32'd0);

    // 1: sky straight after reset release
    rst_vga = 1'b0;
    step(100, 200);
    check("t1_sky", 32'(rgb()), 32'h8CF);
    check("t1_cnt", 32'(o_frame_cnt), 32'd0);
    check("t1_col", 32'(o_collision), 32'd0);

    // 2: player_y change takes effect only after a boundary
    i_player_y = 11'd300;
    step(90, 310);
    check("t2_pre_sky", 32'(rgb()), 32'h8CF);
    boundary();
    check("t2_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
    step(90, 310);
    check("t2_player", 32'(rgb()), 32'hF00);

    // 3: obstacle edges, ground, hidden obs1, inactive region
    i_obs0_x = 11'd200;
    i_obs1_x = 11'd700;
    boundary();
    exp_q.push_back(12'h0F0); step(205, 380); exp_v = exp_q.pop_front(); check("t3_obs", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h0F0); step(215, 380); exp_v = exp_q.pop_front(); check("t3_obs_last", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h8CF); step(216, 380); exp_v = exp_q.pop_front(); check("t3_obs_past", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h8CF); step(199, 380); exp_v = exp_q.pop_front(); check("t3_obs_before", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h630); step(205, 400); exp_v = exp_q.pop_front(); check("t3_ground", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h8CF); step(639, 380); exp_v = exp_q.pop_front(); check("t3_obs1_hidden", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h8CF); step(200, 367); exp_v = exp_q.pop_front(); check("t3_obs_top", 32'(rgb()), 32'(exp_v));
    exp_q.push_back(12'h000); step(650, 10);  exp_v = exp_q.pop_front(); check("t3_inactive", 32'(rgb()), 32'(exp_v));

    // 4: collision flag follows the previous frame's overlap
    i_player_y = 11'd360;
    i_obs0_x   = 11'd100;
    boundary();
    check("t4_col_f3", 32'(o_collision), 32'd0);
    step(105, 370);
    check("t4_overlap_rgb", 32'(rgb()), 32'hF00);
    check("t4_col_still0", 32'(o_collision), 32'd0);
    boundary();
    check("t4_col_set", 32'(o_collision), 32'd1);
    i_obs0_x = 11'd300;
    step(105, 370);
    step(305, 380);
    check("t4_midframe_ignored", 32'(rgb()), 32'h8CF);
    check("t4_col_hold", 32'(o_collision), 32'd1);
    boundary();
    check("t4_col_again", 32'(o_collision), 32'd1);
    step(105, 370);
    step(305, 380);
    check("t4_obs_moved", 32'(rgb()), 32'h0F0);
    boundary();
    check("t4_col_clear", 32'(o_collision), 32'd0);
    check("t4_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

    // 5: game over blinks the player but not the collision
    i_obs0_x    = 11'd100;
    i_game_over = 1'b1;
    boundary();
    for (int f = 0; f < 16; f++) begin
      step(90, 370);
      check("t5_blink_sky", 32'(rgb()), exp_cnt[3] ? 32'h8CF : 32'hF00);
      step(105, 370);
      check("t5_blink_obs", 32'(rgb()), exp_cnt[3] ? 32'h0F0 : 32'hF00);
      boundary();
      check("t5_col", 32'(o_collision), 32'd1);
      check("t5_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
    end

    // Bottom clipping of player and right-edge clipping of obs1
    i_game_over = 1'b0;
    i_player_y  = 11'd470;
    i_obs1_x    = 11'd630;
    boundary();
    step(90, 479);
    check("clip_player_in", 32'(rgb()), 32'hF00);
    step(90, 480);
    check("clip_player_out", 32'(rgb()), 32'h000);
    step(90, 469);
    check("ground_above_player", 32'(rgb()), 32'h630);
    step(639, 380);
    check("clip_obs1_in", 32'(rgb()), 32'h0F0);
    step(640, 380);
    check("clip_obs1_out", 32'(rgb()), 32'h000);

    // 6: frame counter wrap
    for (int i = 0; i < 256; i++) begin
      boundary();
      if (exp_cnt == 8'd255 || exp_cnt == 8'd0) begin
        check("t6_wrap", 32'(o_frame_cnt), 32'(exp_cnt));
      end
    end
    check("t6_cnt_final", 32'(o_frame_cnt), 32'(exp_cnt));

    // Reset mid-line, then render immediately from zero shadows
    step(300, 200);
    check("t6_pre_reset", 32'(rgb()), 32'h8CF);
    rst_vga = 1'b1;
    step(301, 200);
    check("t6_rst_rgb", 32'(rgb()), 32'h000);
    check("t6_rst_cnt", 32'(o_frame_cnt), 32'd0);
    check("t6_rst_col", 32'(o_collision), 32'd0);
    rst_vga = 1'b0;
    step(90, 10);
    check("t6_post_player", 32'(rgb()), 32'hF00);
    step(5, 380);
    check("t6_post_obs", 32'(rgb()), 32'h0F0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
